// File: rtl/alu_cmd_assembler.sv
// rtl/alu_cmd_assembler.sv - frames '=' operand '.' byte stream into 24-bit alu_interface commands
module alu_cmd_assembler #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int ERR_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       char_in,
  input  logic             char_valid,
  output logic [23:0]      input_word,
  output logic             enable,
  output logic             word_strobe,
  output logic             frame_err,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [7:0] CH_START = 8'h3D;
  localparam logic [7:0] CH_TERM  = 8'h2E;
  localparam int         TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_OP, S_TERM} state_t;

  state_t      state, state_nx;
  logic [TW-1:0] tmo, tmo_nx;
  logic [7:0]  operand, operand_nx;
  logic        deliver, drop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      tmo         <= '0;
      operand     <= '0;
      input_word  <= '0;
      enable      <= 1'b0;
      word_strobe <= 1'b0;
      frame_err   <= 1'b0;
      err_count   <= '0;
    end else begin
      state       <= state_nx;
      tmo         <= tmo_nx;
      operand     <= operand_nx;
      word_strobe <= deliver;
      frame_err   <= drop;
      if (deliver) begin
        input_word <= {CH_START, operand, CH_TERM};
        enable     <= 1'b1;
      end
      if (drop && err_count != ERR_MAX)
        err_count <= err_count + ERR_W'(1);
    end
  end

  always_comb begin
    state_nx   = state;
    tmo_nx     = tmo;
    operand_nx = operand;
    deliver    = 1'b0;
    drop       = 1'b0;
    if (state == S_IDLE) begin
      tmo_nx = '0;
      if (char_valid && char_in == CH_START)
        state_nx = S_OP;
    end else if (!char_valid) begin
      // An accepted character on the expiry cycle wins over the timeout.
      if (tmo == TMO_LAST) begin
        state_nx = S_IDLE;
        tmo_nx   = '0;
        drop     = 1'b1;
      end else begin
        tmo_nx = tmo + 1'b1;
      end
    end else begin
      tmo_nx = '0;
      if (state == S_OP) begin
        if (char_in == CH_TERM) begin
          state_nx = S_IDLE;
          drop     = 1'b1;
        end else if (char_in != CH_START) begin
          operand_nx = char_in;
          state_nx   = S_TERM;
        end
      end else begin
        if (char_in == CH_TERM) begin
          state_nx = S_IDLE;
          deliver  = 1'b1;
        end else if (char_in == CH_START) begin
          state_nx = S_OP;
          drop     = 1'b1;
        end else begin
          state_nx = S_IDLE;
          drop     = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_assembler.sv
// tb/tb_alu_cmd_assembler.sv - directed and random checks of alu_cmd_assembler against a frame-queue model
module tb_alu_cmd_assembler;

  localparam int TMO   = 8;
  localparam int ERR_W = 2;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       char_in = 8'h00;
  logic             char_valid = 1'b0;
  logic [23:0]      input_word;
  logic             enable;
  logic             word_strobe;
  logic             frame_err;
  logic [ERR_W-1:0] err_count;

  alu_cmd_assembler #(.TIMEOUT_CYCLES(TMO), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .char_in(char_in), .char_valid(char_valid),
    .input_word(input_word), .enable(enable), .word_strobe(word_strobe),
    .frame_err(frame_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: the characters of the frame in progress, and idle clocks since the last one.
  logic [7:0]  fq[$];
  int          idle = 0;
  logic [23:0] m_word = '0;
  logic        m_en = 1'b0, m_strobe = 1'b0, m_err = 1'b0;
  int          m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic v, input logic [7:0] c);
    m_strobe = 1'b0;
    m_err    = 1'b0;
    if (!rst) begin
      fq.delete(); idle = 0; m_word = '0; m_en = 1'b0; m_cnt = 0;
      return;
    end
    if (v) begin
      idle = 0;
      if (fq.size() == 0) begin
        if (c == 8'h3D) fq.push_back(c);
      end else if (fq.size() == 1) begin
        if (c == 8'h2E) begin m_err = 1'b1; fq.delete(); end
        else if (c != 8'h3D) fq.push_back(c);
      end else begin
        if (c == 8'h2E) begin
          m_word = {fq[0], fq[1], c}; m_strobe = 1'b1; m_en = 1'b1; fq.delete();
        end else begin
          m_err = 1'b1; fq.delete();
          if (c == 8'h3D) fq.push_back(c);
        end
      end
    end else if (fq.size() > 0) begin
      idle++;
      if (idle == TMO) begin m_err = 1'b1; fq.delete(); idle = 0; end
    end
    if (m_err && m_cnt < ERR_MAX) m_cnt++;
  endtask

  task automatic step(input logic v, input logic [7:0] c);
    @(negedge clk);
    char_valid = v;
    char_in    = c;
    @(posedge clk);
    model_step(rst_n, v, c);
    #1;
    chk("input_word", 32'(input_word), 32'(m_word));
    chk("enable", 32'(enable), 32'(m_en));
    chk("word_strobe", 32'(word_strobe), 32'(m_strobe));
    chk("frame_err", 32'(frame_err), 32'(m_err));
    chk("err_count", 32'(err_count), 32'(m_cnt));
  endtask

  task automatic ch(input logic [7:0] c);
    step(1'b1, c);
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    step(1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("reset_word", 32'(input_word), 32'h0);
    chk("reset_enable", 32'(enable), 32'h0);

    ch(8'h3D); idles(1); ch(8'h55); idles(1); ch(8'h2E);
    chk("frame1_word", 32'(input_word), 32'h003D552E);
    chk("frame1_strobe", 32'(word_strobe), 32'h1);
    chk("frame1_enable", 32'(enable), 32'h1);
    idles(1);
    chk("frame1_strobe_drop", 32'(word_strobe), 32'h0);

    ch(8'h3D); ch(8'h4E); ch(8'h2E);
    chk("b2b_word1", 32'(input_word), 32'h003D4E2E);
    ch(8'h3D); ch(8'h41); ch(8'h2E);
    chk("b2b_word2", 32'(input_word), 32'h003D412E);
    chk("b2b_enable", 32'(enable), 32'h1);

    ch(8'h3D); ch(8'h2E);
    chk("empty_err", 32'(frame_err), 32'h1);
    chk("empty_cnt", 32'(err_count), 32'h1);
    chk("empty_word_hold", 32'(input_word), 32'h003D412E);
    ch(8'h3D); ch(8'h3D); ch(8'h0E); ch(8'h2E);
    chk("restart_word", 32'(input_word), 32'h003D0E2E);
    chk("restart_cnt", 32'(err_count), 32'h1);

    do_reset();
    ch(8'h3D); ch(8'h55); idles(7);
    chk("tmo_not_yet", 32'(frame_err), 32'h0);
    idles(1);
    chk("tmo_err", 32'(frame_err), 32'h1);
    chk("tmo_cnt", 32'(err_count), 32'h1);
    ch(8'h2E);
    chk("tmo_late_term", 32'(word_strobe), 32'h0);
    ch(8'h3D); ch(8'h55); idles(7); ch(8'h2E);
    chk("tmo_edge_strobe", 32'(word_strobe), 32'h1);
    chk("tmo_edge_word", 32'(input_word), 32'h003D552E);
    chk("tmo_edge_cnt", 32'(err_count), 32'h1);

    do_reset();
    ch(8'h41); ch(8'h42);
    chk("junk_cnt", 32'(err_count), 32'h0);
    ch(8'h3D); ch(8'h55); ch(8'h58);
    chk("bad_term_err", 32'(frame_err), 32'h1);
    for (int i = 0; i < 4; i++) begin ch(8'h3D); ch(8'h2E); end
    chk("sat_cnt", 32'(err_count), 32'h3);

    do_reset();
    ch(8'h3D); ch(8'h55);
    do_reset();
    chk("midreset_word", 32'(input_word), 32'h0);
    chk("midreset_err", 32'(frame_err), 32'h0);
    ch(8'h2E);
    chk("midreset_strobe", 32'(word_strobe), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r < 5)       ch(8'h3D);
      else if (r < 9)  ch(8'h2E);
      else if (r < 13) ch(8'($urandom));
      else if (r < 18) step(1'b0, 8'($urandom));
      else if (r == 18) idles(int'($urandom_range(6, 10)));
      else begin
        if ($urandom_range(0, 9) == 0) do_reset();
        else step(1'b0, 8'h00);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_cmd_assembler.md
Name: alu_cmd_assembler

Overview:
Upstream feeder for alu_interface. Collects a serial stream of ASCII bytes from the character receiver and frames them into a 3-character command: '=' (0x3D), operand char, '.' (0x2E). Emits the framed 24-bit input_word plus enable, exactly as alu_interface consumes them. Malformed frames, stalled frames and abandoned frames are dropped and counted.

Parameters:
TIMEOUT_CYCLES, 1000000, max idle clocks between characters inside a frame before the partial frame is abandoned (>=2).
ERR_W, 8, width of saturating error counter.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
char_in  input  8  ASCII byte from receiver
char_valid  input  1  char_in valid this cycle, single-cycle per byte, no backpressure
input_word  output  24  framed command {start, operand, terminator} to alu_interface
enable  output  1  high once the first valid frame is delivered, stays high (alu_interface enable)
word_strobe  output  1  one-cycle pulse on each new input_word
frame_err  output  1  one-cycle pulse when a partial frame is dropped
err_count  output  ERR_W  saturating count of dropped frames

Behaviour:
- Reset (rst_n low at clk edge): input_word=0, enable=0, word_strobe=0, frame_err=0, err_count=0, state=S_IDLE, timeout counter=0, operand latch=0. Reset takes priority over all other activity, including mid-frame; a partial frame is discarded without frame_err.
- Only cycles with char_valid=1 consume a character; other cycles only advance the timeout counter.
- FSM:
  - S_IDLE: char 0x3D -> S_OP. Any other char ignored; no error.
  - S_OP: char 0x3D -> stay S_OP (restart frame, no error). Char 0x2E -> S_IDLE, frame_err pulse (empty operand). Any other char -> latch as operand, go to S_TERM.
  - S_TERM: char 0x2E -> S_IDLE, deliver frame. Char 0x3D -> S_OP, frame_err pulse (new start abandons old frame). Any other char -> S_IDLE, frame_err pulse.
- Delivery: on the clock edge that accepts the terminator, input_word <= {8'h3D, operand, 8'h2E}, word_strobe=1 for that one cycle, enable<=1. Latency: outputs visible the cycle after the terminator is sampled. input_word holds until the next delivery or reset; enable never drops except on reset.
- Timeout: counter clears on every accepted char and whenever state=S_IDLE. In S_OP/S_TERM it increments every cycle with char_valid=0. When it reaches TIMEOUT_CYCLES-1 -> S_IDLE, frame_err pulse, counter clears. If char_valid=1 on the expiry cycle, the character is processed normally and the timeout does not fire.
- err_count increments by 1 on every frame_err pulse and saturates at 2^ERR_W-1; no wrap.
- frame_err and word_strobe are never high in the same cycle.
- Operand may be any byte other than 0x3D/0x2E, including control characters; no range checks are made here (alu_interface owns decoding).

Test Plan:
- Reset then bytes 3D,55,2E (one per 2 clocks) -> one cycle after 2E: input_word=24'h3D552E, word_strobe pulse, enable=1; err_count=0.
- Back-to-back frames 3D,4E,2E,3D,41,2E on consecutive cycles -> input_word 3D4E2E then 3D412E, two strobes, enable stays 1 throughout.
- Bytes 3D,2E -> frame_err pulse, err_count=1, input_word unchanged; then 3D,3D,0E,2E -> input_word=3D0E2E, no extra error.
- TIMEOUT_CYCLES=8: send 3D,55 then idle 8 cycles -> frame_err, err_count=1, state idle; following 2E ignored; char landing exactly on expiry cycle completes frame instead.
- Junk 41,42 in S_IDLE -> no error; 3D,55,58 -> frame_err; ERR_W=2 with 5 bad frames -> err_count saturates at 3.
- rst_n low after 3D,55 -> all outputs zero next cycle; 2E afterwards does not produce a strobe.
